// File: rtl/program_load_controller_pkg.sv
// Shared definitions for the program load controller.
//   state_t        : controller FSM states
//   DEFAULT_DEPTH  : default instruction memory depth in words
//   BYTE_ORDER_LE  : 1 = first received byte lands in bits 7:0 of a word
package program_load_controller_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam bit BYTE_ORDER_LE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/program_load_controller_word_assembler.sv
// Assembles four consecutive bytes into a 32-bit instruction word.
//   clk, rst    : clock, asynchronous active-low reset
//   clear       : synchronous clear of byte index and shift register
//   in_valid    : byte accepted this cycle
//   in_byte     : the accepted byte
//   word        : assembled word including the byte presented this cycle
//   word_valid  : high in the cycle the fourth byte of a word is accepted
module program_load_controller_word_assembler
    import program_load_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_idx;
    logic [31:0] shreg;

    // The word is offered combinationally so the controller can latch it in
    // the same cycle the fourth byte arrives, without an extra pipeline stage.
    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        word       = BYTE_ORDER_LE ? {in_byte, shreg[31:8]} : {shreg[23:0], in_byte};
        word_valid = in_valid && (byte_idx == 2'd3);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= 2'd0;
            shreg    <= 32'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            shreg    <= 32'd0;
        end else if (in_valid) begin
            shreg    <= word;
            byte_idx <= byte_idx + 2'd1;   // wraps to 0 after the fourth byte
        end
    end

endmodule

// File: rtl/program_load_controller.sv
// Loads a program from the UART byte stream into the fetch-stage memory.
//   clk, rst            : clock, asynchronous active-low reset
//   i_rx_valid/i_rx_byte: received byte strobe and data
//   i_abort             : synchronous abort back to IDLE (beats i_rx_valid)
//   o_write_enable      : stretched load strobe, WE_HOLD high then WE_HOLD low
//   o_load_address      : word index being written
//   o_load_instruction  : assembled little-endian word
//   o_flush             : one-cycle pulse when a valid header starts a load
//   o_run               : level, program loaded and core may fetch
//   o_load_done         : one-cycle pulse when the last word's write completes
//   o_busy              : loading in progress (RECV/WRITE/GAP)
//   o_error             : bad header, overrun or timeout; cleared by i_abort
module program_load_controller
    import program_load_controller_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int WE_HOLD     = 3,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_abort,
    output logic              o_write_enable,
    output logic [ADDR_W-1:0] o_load_address,
    output logic [31:0]       o_load_instruction,
    output logic              o_flush,
    output logic              o_run,
    output logic              o_load_done,
    output logic              o_busy,
    output logic              o_error
);

    localparam int IDX_W  = ADDR_W + 1;              // can hold DEPTH itself
    localparam int HOLD_W = $clog2(WE_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    state_t             state;
    logic [IDX_W-1:0]   n_words;
    logic [IDX_W-1:0]   word_idx;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               skid_valid;
    logic [7:0]         skid_byte;

    logic               from_skid;
    logic               acc_valid;
    logic [7:0]         acc_byte;
    logic               hdr_accept;
    logic               hdr_ok;
    logic               asm_valid;
    logic               asm_clear;
    logic [31:0]        word;
    logic               word_valid;

    // A byte parked in the skid during WRITE/GAP takes precedence over the
    // live input so byte order is preserved.
    always_comb begin
        from_skid  = skid_valid && (state == ST_RECV || state == ST_DONE);
        acc_valid  = !i_abort && (from_skid ||
                     (i_rx_valid && (state inside {ST_IDLE, ST_RECV, ST_DONE})));
        acc_byte   = from_skid ? skid_byte : i_rx_byte;
        hdr_accept = acc_valid && (state == ST_IDLE || state == ST_DONE);
        hdr_ok     = (acc_byte != 8'd0) && (acc_byte <= 8'(DEPTH));
        asm_valid  = acc_valid && (state == ST_RECV);
        asm_clear  = i_abort || hdr_accept;
    end

    program_load_controller_word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .in_valid   (asm_valid),
        .in_byte    (acc_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            n_words            <= '0;
            word_idx           <= '0;
            hold_cnt           <= '0;
            tmo_cnt            <= '0;
            skid_valid         <= 1'b0;
            skid_byte          <= 8'd0;
            o_write_enable     <= 1'b0;
            o_load_address     <= '0;
            o_load_instruction <= 32'd0;
            o_flush            <= 1'b0;
            o_run              <= 1'b0;
            o_load_done        <= 1'b0;
            o_busy             <= 1'b0;
            o_error            <= 1'b0;
        end else begin
            o_flush     <= 1'b0;
            o_load_done <= 1'b0;

            if (i_abort) begin
                state          <= ST_IDLE;
                n_words        <= '0;
                word_idx       <= '0;
                hold_cnt       <= '0;
                tmo_cnt        <= '0;
                skid_valid     <= 1'b0;
                o_write_enable <= 1'b0;
                o_run          <= 1'b0;
                o_busy         <= 1'b0;
                o_error        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (acc_valid) begin
                            if (from_skid) begin
                                skid_valid <= i_rx_valid;
                                skid_byte  <= i_rx_byte;
                            end
                            o_run <= 1'b0;
                            if (hdr_ok) begin
                                n_words  <= acc_byte[IDX_W-1:0];
                                word_idx <= '0;
                                tmo_cnt  <= '0;
                                o_flush  <= 1'b1;
                                o_busy   <= 1'b1;
                                state    <= ST_RECV;
                            end else begin
                                o_error <= 1'b1;
                                state   <= ST_ERR;
                            end
                        end
                    end

                    ST_RECV: begin
                        if (acc_valid) begin
                            tmo_cnt <= '0;
                            if (from_skid) begin
                                skid_valid <= i_rx_valid;
                                skid_byte  <= i_rx_byte;
                            end
                            if (word_valid) begin
                                o_write_enable     <= 1'b1;
                                o_load_address     <= word_idx[ADDR_W-1:0];
                                o_load_instruction <= word;
                                hold_cnt           <= '0;
                                state              <= ST_WRITE;
                            end
                        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                            o_busy  <= 1'b0;
                            o_error <= 1'b1;
                            state   <= ST_ERR;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end

                    // Address and instruction registers are simply not
                    // touched here, which keeps them stable for the fetch stage.
                    ST_WRITE, ST_GAP: begin
                        if (i_rx_valid && skid_valid) begin
                            o_write_enable <= 1'b0;
                            o_busy         <= 1'b0;
                            o_error        <= 1'b1;
                            state          <= ST_ERR;
                        end else begin
                            if (i_rx_valid) begin
                                skid_valid <= 1'b1;
                                skid_byte  <= i_rx_byte;
                            end
                            if (hold_cnt == HOLD_W'(WE_HOLD - 1)) begin
                                hold_cnt <= '0;
                                if (state == ST_WRITE) begin
                                    o_write_enable <= 1'b0;
                                    state          <= ST_GAP;
                                end else begin
                                    word_idx <= word_idx + IDX_W'(1);
                                    if (word_idx + IDX_W'(1) == n_words) begin
                                        o_load_done <= 1'b1;
                                        o_run       <= 1'b1;
                                        o_busy      <= 1'b0;
                                        state       <= ST_DONE;
                                    end else begin
                                        tmo_cnt <= '0;
                                        state   <= ST_RECV;
                                    end
                                end
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                    end

                    ST_ERR: ;   // held until i_abort

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/program_load_controller.md
# program_load_controller

Sequences program loading into the 8-entry instruction memory of the fetch stage. It accepts a byte stream from the UART receiver, assembles little-endian 32-bit words, and drives the fetch stage's write-enable/address/instruction load port with stretched, edge-detectable strobes. It then releases the core to run and issues a pipeline flush when a new program load begins. It sits between the UART RX block and the instruction fetch stage.

## Interface
Parameters:
- DEPTH, 8, instruction memory words; must equal the fetch stage memory depth
- ADDR_W, 3, load address width, $clog2(DEPTH)
- WE_HOLD, 3, cycles o_write_enable is held high, and then held low, per word (≥3; the fetch stage edge-detects through a 2-flop delay)
- TIMEOUT_CYC, 1000000, idle cycles allowed between bytes in RECV before error

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- i_rx_valid  in  1  one-cycle pulse, byte valid
- i_rx_byte  in  8  received byte
- i_abort  in  1  synchronous abort; returns to IDLE from any state
- o_write_enable  out  1  load strobe to fetch stage
- o_load_address  out  ADDR_W  word index being written
- o_load_instruction  out  32  assembled word
- o_flush  out  1  one-cycle pulse at start of each new load
- o_run  out  1  level; program loaded, core may fetch
- o_load_done  out  1  one-cycle pulse when last word's write completes
- o_busy  out  1  high in RECV/WRITE/GAP
- o_error  out  1  high in ERR

## Operation
- Reset values: all outputs 0; state IDLE; counters and skid register cleared.
- Protocol: header byte N (word count), then 4·N data bytes, little-endian (first byte → bits 7:0).
- IDLE: accepted byte is header. N=0 or N>DEPTH → ERR. Otherwise latch N, word index 0, byte index 0, pulse o_flush, → RECV.
- RECV: each byte is shifted into the assembly register, and the byte index increments. The 4th byte → WRITE with the address equal to the word index. The timeout counter resets on every accepted byte; reaching TIMEOUT_CYC → ERR.
- WRITE: o_write_enable=1 for WE_HOLD cycles; address and instruction stay stable throughout → GAP.
- GAP: o_write_enable=0 for WE_HOLD cycles; address/instruction held. Word index increments on exit. If the index equals N → DONE with an o_load_done pulse; else → RECV.
- Skid register: a byte arriving in WRITE/GAP is held in a 1-entry skid. It is consumed on the first RECV cycle as an accepted byte. A second byte while the skid is full → ERR (overrun).
- DONE: o_run=1. An accepted byte is treated as a new header, processed exactly as in IDLE (o_run drops the same cycle the flush pulses).
- ERR: o_error=1, o_run=0, bytes ignored; only i_abort exits.
- i_abort has priority over i_rx_valid in the same cycle. It clears the skid, counters, and o_run. An abort during WRITE drops o_write_enable next cycle.
- Arithmetic: word index is ADDR_W+1 bits, so it can represent DEPTH; byte index is 2 bits and wraps naturally.

## Timing
- Header accepted at cycle c: o_flush=1 at c+1, state RECV at c+1.
- 4th data byte at cycle c: o_write_enable high on cycles c+1..c+WE_HOLD, low on cycles c+WE_HOLD+1..c+2·WE_HOLD.
- Last word: o_load_done=1 and o_run=1 from cycle c+2·WE_HOLD+1.
- Error detection: ERR registered one cycle after the offending byte or timeout.

## Structure
- Shared package (e.g. load_pkg): state encoding IDLE/RECV/WRITE/GAP/DONE/ERR, byte-order constant, default DEPTH.
- Sub-module word_assembler: 2-bit byte index, 32-bit shift register, word_valid pulse, clear input.
- Top level holds the FSM, strobe counter, timeout counter, and skid register.

## Test plan
- Header 0x02, bytes 13 00 00 00 93 00 10 00 → writes 0x00000013@0 and 0x00100093@1. Each o_write_enable high exactly 3 cycles, then o_load_done and o_run.
- Header 0x00, and separately 0x09 → o_error=1, no writes; i_abort → IDLE, o_error=0.
- Data byte injected during WRITE → absorbed by skid, correct word. Two bytes injected during GAP → ERR.
- Header 0x01 followed by 2 data bytes, then silence for TIMEOUT_CYC (set to 16) → ERR at cycle 17, no write issued.
- After DONE, header 0x01 plus 4 bytes → o_flush pulse, o_run low until reload completes, then address 0 overwritten.
- i_abort asserted mid-WRITE → o_write_enable low next cycle, state IDLE, o_busy=0.
